// File: rtl/ccff_bitstream_shifter.sv
// Word-to-serial loader for a ccff configuration chain.
// Accepts WORD_W-bit words from the host and shifts exactly CHAIN_LEN bits into the
// chain head. Bit [0] of each word goes out first. The final word is truncated when
// CHAIN_LEN is not a multiple of WORD_W.
module ccff_bitstream_shifter #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 20
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [0:WORD_W-1] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              config_enable,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BL_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W = $clog2(WORD_W + 1);

    // An empty chain has nothing to load, so refuse to elaborate.
    if (CHAIN_LEN < 1) begin : g_chain_len_check
        $error("ccff_bitstream_shifter: CHAIN_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e            state_q;
    logic [BL_W-1:0]   bits_left_q;
    logic [WB_W-1:0]   word_bits_q;
    logic [0:WORD_W-1] shift_q;
    logic [0:WORD_W-1] shift_next;
    logic [WB_W-1:0]   load_bits;
    logic              ccff_head_q;
    logic              config_enable_q;
    logic              done_q;
    logic              last_word_bit;
    logic              last_chain_bit;

    // Shift one position toward [0], filling the tail with zero.
    if (WORD_W > 1) begin : g_shift_wide
        assign shift_next = {shift_q[1:WORD_W-1], 1'b0};
    end else begin : g_shift_narrow
        assign shift_next = '0;
    end

    // Bits to shift from the word being accepted: a full word, or whatever remains.
    always_comb begin
        load_bits = '0;
        if (32'(bits_left_q) >= WORD_W) begin
            load_bits = WB_W'(WORD_W);
        end else begin
            load_bits = WB_W'(bits_left_q);
        end
    end

    assign last_word_bit  = (word_bits_q == WB_W'(1));
    assign last_chain_bit = (bits_left_q == BL_W'(1));

    // Control FSM with counters, shift register and registered chain outputs.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q         <= StIdle;
            bits_left_q     <= '0;
            word_bits_q     <= '0;
            shift_q         <= '0;
            ccff_head_q     <= 1'b0;
            config_enable_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        done_q      <= 1'b0;
                        bits_left_q <= BL_W'(CHAIN_LEN);
                        state_q     <= StLoad;
                    end
                end

                StLoad: begin
                    if (word_valid) begin
                        shift_q         <= word_data;
                        word_bits_q     <= load_bits;
                        // Present bit [0] during the first SHIFT cycle.
                        config_enable_q <= 1'b1;
                        ccff_head_q     <= word_data[0];
                        state_q         <= StShift;
                    end
                end

                StShift: begin
                    shift_q     <= shift_next;
                    word_bits_q <= word_bits_q - WB_W'(1);
                    bits_left_q <= bits_left_q - BL_W'(1);
                    if (last_word_bit) begin
                        // Unshifted tail bits of a truncated final word are dropped here.
                        config_enable_q <= 1'b0;
                        ccff_head_q     <= 1'b0;
                        if (last_chain_bit) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StLoad;
                        end
                    end else begin
                        config_enable_q <= 1'b1;
                        ccff_head_q     <= shift_next[0];
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign word_ready    = (state_q == StLoad);
    assign busy          = (state_q == StLoad) || (state_q == StShift);
    assign ccff_head     = ccff_head_q;
    assign config_enable = config_enable_q;
    assign done          = done_q;

endmodule
